enc_code_logger: RTL and testbench

ENC_CODE_LOGGER -- requirements
Module: enc_code_logger

---
 rtl/enc_log_pkg.sv | 11 +
 rtl/enc_log_fifo.sv | 64 ++++++
 rtl/enc_code_logger.sv | 81 ++++++++
 tb/tb_enc_code_logger.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_log_pkg.sv
// Shared types and defaults for the encoder code logger.
package enc_log_pkg;

    typedef logic [1:0] code_t;

    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

endpackage

// File: rtl/enc_log_fifo.sv
// Small code FIFO with occupancy count and drop-on-full indication.
module enc_log_fifo
    import enc_log_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  code_t                    din,
    input  logic                     ready,
    output code_t                    dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    code_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  cnt;
    logic           full;
    logic           pop;
    logic           wr;

    assign full  = (cnt == LW'(DEPTH));
    assign valid = (cnt != '0);
    assign pop   = valid & ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign level = cnt;
    assign dout  = valid ? mem[rd_ptr] : code_t'(2'b00);

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/enc_code_logger.sv
// Captures encoder code changes into a FIFO and keeps per-code hit counters.
module enc_code_logger
    import enc_log_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a,
    input  logic                     b,
    input  logic                     in_valid,
    output logic [1:0]               out_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic [1:0]               count_sel,
    output logic [CNT_W-1:0]         count_val
);

    localparam logic [CNT_W-1:0] MAX = '1;

    code_t              code;
    code_t              last_code;
    logic               last_valid;
    logic               capture;
    logic               drop;
    logic [CNT_W-1:0]   cnt [4];

    assign code    = {a, b};
    assign capture = in_valid & (~last_valid | (code != last_code));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid <= 1'b0;
            last_code  <= '0;
        end else begin
            last_valid <= in_valid;
            if (in_valid) begin
                last_code <= code;
            end
        end
    end

    enc_log_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   (code),
        .ready (out_ready),
        .dout  (out_code),
        .valid (out_valid),
        .level (level),
        .drop  (drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Dropped captures are still counted; counters stick at their maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else if (capture && cnt[code] != MAX) begin
            cnt[code] <= cnt[code] + CNT_W'(1);
        end
    end

    assign count_val = cnt[count_sel];

endmodule

// File: tb/tb_enc_code_logger.sv
// Randomised and directed checks of enc_code_logger against a queue model.
module tb_enc_code_logger;

    localparam int DEPTH = 4;
    localparam int MAXC  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] count_sel = 2'b00;
    logic [1:0] out_code;
    logic       out_valid;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] count_val;

    int compared = 0;
    int mismatched = 0;

    logic [1:0] mq [$];
    bit         m_ovf;
    int         m_cnt [4];
    bit         m_lv;
    logic [1:0] m_lc;

    enc_code_logger #(
        .DEPTH (DEPTH),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .count_sel (count_sel),
        .count_val (count_val)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_head();
        return (mq.size() > 0) ? mq[0] : 2'b00;
    endfunction

    // Drive one cycle from a negedge, update the model at the edge, return at the next negedge.
    task automatic cyc(input bit r, input bit v, input logic [1:0] c, input bit rdy);
        bit cap;
        bit pop;
        bit full;
        rst = r;
        in_valid = v;
        {a, b} = c;
        out_ready = rdy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_lv = 0;
            m_lc = 2'b00;
        end else begin
            cap  = v && (!m_lv || c != m_lc);
            full = (mq.size() == DEPTH);
            pop  = (mq.size() > 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (!full || pop) mq.push_back(c);
                else m_ovf = 1;
                if (m_cnt[c] < MAXC) m_cnt[c]++;
            end
            m_lv = v;
            if (v) m_lc = c;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1, 0, 2'b00, 0);
        cyc(1, 1, 2'b11, 1);
        cyc(0, 0, 2'b00, 0);
        compared++;
        if (level !== 3'd0 || out_valid !== 1'b0 || out_code !== 2'b00 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: level=%0d valid=%b code=%b ovf=%b want 0/0/00/0",
                     level, out_valid, out_code, overflow);
        end
        for (int s = 0; s < 4; s++) begin
            count_sel = s[1:0];
            #1;
            compared++;
            if (count_val !== 8'd0) begin
                mismatched++;
                $display("FAIL reset_count[%0d]: got %0d want 0", s, count_val);
            end
        end
    endtask

    task automatic test_hold();
        cyc(1, 0, 2'b00, 0);
        cyc(0, 1, 2'b10, 0);
        compared++;
        if (out_valid !== 1'b1 || out_code !== 2'b10) begin
            mismatched++;
            $display("FAIL hold_latency: valid=%b code=%b want 1/10", out_valid, out_code);
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 2'b10, 0);
        count_sel = 2'd2;
        #1;
        compared++;
        if (level !== 3'd1 || count_val !== 8'd1) begin
            mismatched++;
            $display("FAIL hold_once: level=%0d cnt2=%0d want 1/1", level, count_val);
        end
        cyc(0, 0, 2'b10, 0);
        cyc(0, 1, 2'b10, 0);
        #1;
        compared++;
        if (level !== 3'd2 || count_val !== 8'd2 || 3'(mq.size()) !== 3'd2) begin
            mismatched++;
            $display("FAIL hold_revalid: level=%0d cnt2=%0d want 2/2", level, count_val);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] seq [4];
        logic [1:0] want [3];
        logic [1:0] exp;
        seq = '{2'b00, 2'b01, 2'b01, 2'b11};
        want = '{2'b00, 2'b01, 2'b11};
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, seq[i], 0);
        compared++;
        if (level !== 3'd3) begin
            mismatched++;
            $display("FAIL seq_level: got %0d want 3", level);
        end
        for (int s = 0; s < 4; s++) begin
            count_sel = s[1:0];
            #1;
            compared++;
            if (count_val !== 8'(m_cnt[s]) || count_val !== ((s == 2) ? 8'd0 : 8'd1)) begin
                mismatched++;
                $display("FAIL seq_count[%0d]: got %0d want %0d", s, count_val, m_cnt[s]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp = m_head();
            compared++;
            if (out_code !== want[i] || out_code !== exp) begin
                mismatched++;
                $display("FAIL seq_order[%0d]: got %b want %b", i, out_code, want[i]);
            end
            cyc(0, 0, 2'b00, 1);
        end
        compared++;
        if (out_valid !== 1'b0 || out_code !== 2'b00) begin
            mismatched++;
            $display("FAIL seq_empty: valid=%b code=%b want 0/00", out_valid, out_code);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] seq [5];
        seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, seq[i], 0);
        count_sel = 2'd0;
        #1;
        compared++;
        if (level !== 3'd4 || overflow !== 1'b1 || count_val !== 8'd2 || out_code !== 2'b00) begin
            mismatched++;
            $display("FAIL overflow_drop: level=%0d ovf=%b cnt0=%0d head=%b want 4/1/2/00",
                     level, overflow, count_val, out_code);
        end
    endtask

    task automatic test_full_pop();
        logic [1:0] seq [4];
        seq = '{2'b00, 2'b01, 2'b10, 2'b11};
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, seq[i], 0);
        cyc(0, 1, 2'b00, 1);
        compared++;
        if (level !== 3'd4 || out_code !== 2'b01 || overflow !== 1'b0 || out_code !== m_head()) begin
            mismatched++;
            $display("FAIL full_pop: level=%0d head=%b ovf=%b want 4/01/0", level, out_code, overflow);
        end
    endtask

    task automatic test_saturate();
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 600; i++) cyc(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, 1);
        for (int s = 0; s < 4; s++) begin
            count_sel = s[1:0];
            #1;
            compared++;
            if (count_val !== 8'(m_cnt[s]) || count_val !== ((s == 1 || s == 2) ? 8'd255 : 8'd0)) begin
                mismatched++;
                $display("FAIL sat_count[%0d]: got %0d want %0d", s, count_val, m_cnt[s]);
            end
        end
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL sat_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq [5];
        seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, seq[i], 0);
        cyc(0, 0, 2'b00, 1);
        compared++;
        if (level !== 3'd3 || overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset: level=%0d ovf=%b want 3/1", level, overflow);
        end
        cyc(1, 1, 2'b10, 1);
        compared++;
        if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_code !== 2'b00) begin
            mismatched++;
            $display("FAIL mid_reset: level=%0d valid=%b ovf=%b want 0/0/0", level, out_valid, overflow);
        end
        for (int s = 0; s < 4; s++) begin
            count_sel = s[1:0];
            #1;
            compared++;
            if (count_val !== 8'd0) begin
                mismatched++;
                $display("FAIL mid_reset_count[%0d]: got %0d want 0", s, count_val);
            end
        end
    endtask

    task automatic test_random();
        bit r;
        bit v;
        bit rdy;
        logic [1:0] c;
        int sel;
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 3) != 0);
            c   = 2'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 2) == 0);
            cyc(r, v, c, rdy);
            compared++;
            if (level !== 3'(mq.size()) || out_valid !== (mq.size() > 0) ||
                out_code !== m_head() || overflow !== m_ovf) begin
                mismatched++;
                $display("FAIL rand_state @%0d: lvl=%0d/%0d val=%b code=%b/%b ovf=%b/%b",
                         i, level, mq.size(), out_valid, out_code, m_head(), overflow, m_ovf);
            end
            sel = $urandom_range(0, 3);
            count_sel = 2'(sel);
            #1;
            compared++;
            if (count_val !== 8'(m_cnt[sel])) begin
                mismatched++;
                $display("FAIL rand_count[%0d] @%0d: got %0d want %0d", sel, i, count_val, m_cnt[sel]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hold();
        test_sequence();
        test_overflow();
        test_full_pop();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
